tune_controller: RTL

- Frame-level sequencer for the pitch-shift path: capture a frame of samples, run the frequency shifter on it, then play the frame out.
- Drives the shifter's Start/Done handshake and latches the shift amount per frame.
- Enforces a Done timeout and provides abort.
- Sits between the user-control front end, the ADC capture buffer, the shifter and the DAC playback logic.

---
 rtl/tune_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tune_controller.sv
// tune_controller: frame sequencer for the pitch-shift path.
// Captures FRAME_LEN samples, starts the shifter and waits for its Done
// rising edge (bounded by TIMEOUT cycles), then plays FRAME_LEN samples out.
// Abort returns to IDLE from any busy state without a FrameDone pulse.
module tune_controller #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned SHIFT_W   = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Go,
  input  logic               Abort,
  input  logic [SHIFT_W-1:0] Semitones,
  input  logic               SampleValid,
  input  logic               PlayReady,
  input  logic               ShiftDone,
  output logic               ShiftStart,
  output logic [SHIFT_W-1:0] ShiftAmount,
  output logic               CaptureEn,
  output logic               PlayEn,
  output logic               Busy,
  output logic               FrameDone,
  output logic               Error,
  output logic [1:0]         Phase
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_PLAY    = 2'd3
  } state_t;

  // Terminal counts, compared against the 16-bit counters.
  localparam logic [15:0] LAST_SAMPLE = 16'(FRAME_LEN - 1);
  localparam logic [15:0] LAST_WAIT   = 16'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          tmo_q, tmo_d;
  logic                 done_dly_q;
  logic                 start_q, start_d;
  logic                 frame_done_q, frame_done_d;
  logic                 error_q, error_d;
  logic [SHIFT_W-1:0]   amount_q, amount_d;
  logic                 done_edge_s;
  logic                 edge_valid_s;

  // Next-state and registered-output computation for the frame sequencer.
  always_comb begin
    // A Done edge in the ShiftStart cycle belongs to a previous operation.
    done_edge_s  = ShiftDone & ~done_dly_q;
    edge_valid_s = done_edge_s & ~start_q;

    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    error_d      = error_q;
    amount_d     = amount_q;

    case (state_q)
      ST_IDLE: begin
        if (Go && !Abort) begin
          amount_d = Semitones;
          error_d  = 1'b0;
          state_d  = ST_CAPTURE;
          cnt_d    = 16'd0;
          tmo_d    = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CAPTURE: begin
        if (Abort) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          tmo_d   = 16'd0;
        end else if (SampleValid) begin
          if (cnt_q == LAST_SAMPLE) begin
            state_d = ST_SHIFT;
            cnt_d   = 16'd0;
            tmo_d   = 16'd0;
            start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_SHIFT: begin
        if (Abort) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          tmo_d   = 16'd0;
        end else if (edge_valid_s) begin
          state_d = ST_PLAY;
          cnt_d   = 16'd0;
          tmo_d   = 16'd0;
        end else if (tmo_q == LAST_WAIT) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          cnt_d   = 16'd0;
          tmo_d   = 16'd0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_PLAY: begin
        if (Abort) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          tmo_d   = 16'd0;
        end else if (PlayReady) begin
          if (cnt_q == LAST_SAMPLE) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
            cnt_d        = 16'd0;
            tmo_d        = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        tmo_d   = 16'd0;
      end
    endcase
  end

  // State, counters, Done delay and registered pulse/flag outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      tmo_q        <= 16'd0;
      done_dly_q   <= 1'b0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      amount_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      done_dly_q   <= ShiftDone;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
      amount_q     <= amount_d;
    end
  end

  // Status outputs decode directly from the registered state.
  assign Phase       = state_q;
  assign CaptureEn   = (state_q == ST_CAPTURE);
  assign PlayEn      = (state_q == ST_PLAY);
  assign Busy        = (state_q != ST_IDLE);
  assign ShiftStart  = start_q;
  assign FrameDone   = frame_done_q;
  assign Error       = error_q;
  assign ShiftAmount = amount_q;

endmodule
